// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB-first, one full-adder slice per cycle.
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_sum_bit,
  output logic             o_bit_valid
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_p, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_cout, r_busy, r_done, r_sum_bit, r_bit_valid;
  logic             w_hs, w_s, w_c, w_last;
  logic [WIDTH-1:0] w_p;
  // two half-adder stages plus an OR form the full-adder slice
  always_comb begin
    w_hs   = r_a[0] ^ r_b[0];
    w_s    = w_hs ^ r_c;
    w_c    = (r_a[0] & r_b[0]) | (r_c & w_hs);
    w_p    = {w_s, r_p[WIDTH-1:1]};
    w_last = r_cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_cout      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sum_bit   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done      <= 1'b0;
          r_sum_bit   <= 1'b0;
          r_bit_valid <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_c     <= i_cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a         <= r_a >> 1;
          r_b         <= r_b >> 1;
          r_p         <= w_p;
          r_c         <= w_c;
          r_sum_bit   <= w_s;
          r_bit_valid <= 1'b1;
          r_cnt       <= w_last ? r_cnt : r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_p;
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done      <= 1'b0;
          r_sum_bit   <= 1'b0;
          r_bit_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_sum_bit   = r_sum_bit;
  assign o_bit_valid = r_bit_valid;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random adds against an arithmetic reference {cout,sum} = a+b+cin.
module tb_serial_adder_ctrl;
  localparam int W = 4;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, sum_bit, bit_valid;
  logic [W-1:0] sum;
  int           total = 0, bad = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout),
    .o_sum_bit(sum_bit), .o_bit_valid(bit_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".bit_valid"}, bit_valid, 0);
    chk({tag, ".sum"}, sum, m_sum);
    chk({tag, ".cout"}, cout, m_cout);
  endtask

  // Accepts an add from IDLE and checks every cycle up to and including the DONE cycle.
  task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input bit noise);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    start = 1'b1; a = x; b = y; cin = ci;
    tick;
    chk("accept.busy", busy, 1);
    chk("accept.done", done, 0);
    chk("accept.bit_valid", bit_valid, 0);
    for (int i = 0; i < W; i++) begin
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (noise) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(1));
      end
      tick;
      chk("shift.sum_bit", sum_bit, r[i]);
      chk("shift.bit_valid", bit_valid, 1);
      chk("shift.busy", busy, i < W - 1);
      chk("shift.done", done, i == W - 1);
      if (i < W - 1) begin
        chk("shift.sum_hold", sum, m_sum);
        chk("shift.cout_hold", cout, m_cout);
      end
    end
    m_sum = r[W-1:0];
    m_cout = r[W];
    chk("done.sum", sum, m_sum);
    chk("done.cout", cout, m_cout);
  endtask

  // A start raised during DONE must be ignored, leaving the block in IDLE.
  task automatic leave_done;
    start = 1'b1; a = 7; b = 7; cin = 1'b1;
    tick;
    chk_idle("after_done");
    start = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    chk("rst.sum_bit", sum_bit, 0);
    chk("rst.bit_valid", bit_valid, 0);
    rst_n = 1'b1;
    tick;
    chk_idle("idle");
    run_add(4, 5, 0, 0);
    leave_done;
    run_add(15, 1, 0, 0);
    leave_done;
    run_add(15, 15, 1, 0);
    leave_done;
    run_add(3, 3, 0, 1);
    leave_done;
    run_add(2, 2, 0, 0);
    leave_done;
    start = 1'b1; a = 9; b = 9; cin = 1'b0;
    tick;
    start = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    m_sum = '0;
    m_cout = 1'b0;
    chk("abort.sum_bit", sum_bit, 0);
    chk_idle("abort");
    rst_n = 1'b1;
    tick;
    chk_idle("abort_idle");
    run_add(1, 1, 0, 0);
    leave_done;
    run_add(6, 7, 0, 0);
    leave_done;
    for (int k = 0; k < 20; k++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
      leave_done;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
